clk_div_prog: RTL and testbench

- Parametrised, runtime-programmable integer clock divider. It succeeds the fixed divide-by-six block.
- Generates `clk_out` at f(sys_clk)/N with exact 50% duty for both even and odd N.
- Also produces a one-cycle `tick` strobe in the sys_clk domain, aligned to each `clk_out` rising edge.
- Sits beside the system clock source and feeds slow peripheral logic: LED scanners, UART baud ticks, sampling strobes.

---
 rtl/clk_div_prog.sv | 74 +++++++
 tb/tb_clk_div_prog.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_prog.sv
// clk_div_prog: runtime-programmable integer clock divider with 50% duty for even and odd N,
// plus a sys_clk-domain tick aligned to each clk_out rise.
module clk_div_prog #(
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 6
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             en,
    input  logic             div_load,
    input  logic [DIV_W-1:0] div_val,
    output logic             div_ack,
    output logic             div_err,
    output logic [DIV_W-1:0] cur_div,
    output logic             clk_out,
    output logic             tick
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t           state, state_nx;
    logic [DIV_W-1:0] cnt, cnt_nx, pending_div, div_nx;
    logic [DIV_W:0]   half;
    logic             pending, pending_nx, clk_p, clk_n, odd;
    logic             run, last, load_ok, load_bad, apply, ack_nx;

    assign run      = state == RUN;
    assign last     = cnt == cur_div - DIV_W'(1);
    assign load_ok  = div_load && div_val >= DIV_W'(2);
    assign load_bad = div_load && div_val < DIV_W'(2);
    assign half     = ({1'b0, cur_div} + (DIV_W+1)'(1)) >> 1;
    // A new divisor may only land where no period is in flight.
    assign apply    = !run || last;

    always_comb begin
        state_nx   = run ? ((last && !en) ? IDLE : RUN) : (en ? RUN : IDLE);
        cnt_nx     = (run && !last) ? cnt + DIV_W'(1) : '0;
        ack_nx     = apply && (load_ok || pending);
        div_nx     = !ack_nx ? cur_div : (load_ok ? div_val : pending_div);
        pending_nx = !ack_nx && (pending || load_ok);
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state       <= IDLE;
            cnt         <= '0;
            clk_p       <= 1'b0;
            tick        <= 1'b0;
            div_ack     <= 1'b0;
            div_err     <= 1'b0;
            cur_div     <= DIV_W'(DEFAULT_DIV);
            odd         <= 1'(DEFAULT_DIV % 2);
            pending     <= 1'b0;
            pending_div <= DIV_W'(DEFAULT_DIV);
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            clk_p   <= run && ({1'b0, cnt} < half);
            tick    <= run && cnt == '0;
            div_ack <= ack_nx;
            div_err <= load_bad;
            cur_div <= div_nx;
            odd     <= div_nx[0];
            pending <= pending_nx;
            if (load_ok) pending_div <= div_val;
        end
    end

    // Half-cycle delayed copy trims the odd-N high phase by half a sys_clk period.
    always_ff @(negedge sys_clk or posedge sys_rst) begin
        if (sys_rst) clk_n <= 1'b0;
        else clk_n <= clk_p;
    end

    assign clk_out = odd ? (clk_p & clk_n) : clk_p;
endmodule

// File: tb/tb_clk_div_prog.sv
// tb_clk_div_prog: scenario tasks checking clk_out timing, tick alignment and divisor loading
// against expectations computed from divisor arithmetic and observed tick history.
`timescale 1ns/1ps
module tb_clk_div_prog;
    localparam int W = 8;
    logic         sys_clk = 1'b0, sys_rst = 1'b1, en = 1'b0, div_load = 1'b0;
    logic [W-1:0] div_val = '0;
    logic         div_ack, div_err, clk_out, tick;
    logic [W-1:0] cur_div;
    int           n_checks = 0, n_fail = 0;
    int           cyc = 0;
    int           tick_c[$], ack_c[$], err_c[$];
    time          tick_t[$], rise_t[$], fall_t[$];

    clk_div_prog #(.DIV_W(W), .DEFAULT_DIV(6)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .en(en), .div_load(div_load), .div_val(div_val),
        .div_ack(div_ack), .div_err(div_err), .cur_div(cur_div), .clk_out(clk_out), .tick(tick)
    );

    always #10 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    always @(negedge sys_clk) begin
        if (tick === 1'b1) begin
            tick_c.push_back(cyc);
            tick_t.push_back($time - 10);
        end
        if (div_ack === 1'b1) ack_c.push_back(cyc);
        if (div_err === 1'b1) err_c.push_back(cyc);
    end
    always @(posedge clk_out) rise_t.push_back($time);
    always @(negedge clk_out) fall_t.push_back($time);

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    function automatic int latest_tick(input int l);
        int r = -1;
        foreach (tick_c[i]) if (tick_c[i] <= l) r = tick_c[i];
        return r;
    endfunction

    task automatic measure(output longint hi, output longint per, output longint off, output int gap);
        int s, k;
        s = rise_t.size(); k = 0; hi = -1; per = -1; off = -1; gap = -1;
        while (rise_t.size() < s + 2 && k < 2000) begin step(1); k++; end
        step(1);
        if (rise_t.size() < s + 2) return;
        per = longint'(rise_t[s+1] - rise_t[s]);
        for (int i = 0; i < fall_t.size(); i++)
            if (fall_t[i] > rise_t[s]) begin hi = longint'(fall_t[i] - rise_t[s]); break; end
        for (int i = 0; i < tick_t.size(); i++)
            if (tick_t[i] <= rise_t[s]) off = longint'(rise_t[s] - tick_t[i]);
        if (tick_c.size() >= 2) gap = tick_c[tick_c.size()-1] - tick_c[tick_c.size()-2];
    endtask

    task automatic wait_ack(input int na, input int lim);
        int k = 0;
        while (ack_c.size() == na && k < lim) begin step(1); k++; end
    endtask

    task automatic test_reset;
        step(2);
        n_checks++; if (clk_out !== 1'b0) begin n_fail++; $display("FAIL reset_clk_out: got %b expected 0", clk_out); end
        n_checks++; if (tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %b expected 0", tick); end
        n_checks++; if (div_ack !== 1'b0 || div_err !== 1'b0) begin n_fail++; $display("FAIL reset_ack_err: got %b%b expected 00", div_ack, div_err); end
        n_checks++; if (cur_div !== 8'd6) begin n_fail++; $display("FAIL reset_cur_div: got %0d expected 6", cur_div); end
        sys_rst = 1'b0;
        step(4);
        n_checks++; if (clk_out !== 1'b0 || tick_c.size() != 0) begin n_fail++; $display("FAIL idle_quiet: clk_out %b ticks %0d expected 0 0", clk_out, tick_c.size()); end
    endtask

    task automatic test_default;
        int e, k; longint hi, per, off; int gap;
        en = 1'b1; e = cyc + 1; k = 0;
        while (tick_c.size() == 0 && k < 20) begin step(1); k++; end
        n_checks++; if (tick_c.size() == 0 || tick_c[0] != e + 1) begin n_fail++; $display("FAIL first_tick: got %0d expected %0d", tick_c.size() ? tick_c[0] : -1, e + 1); end
        measure(hi, per, off, gap);
        n_checks++; if (per != 120 || hi != 60) begin n_fail++; $display("FAIL default_timing: period %0d high %0d expected 120 60", per, hi); end
        n_checks++; if (off != 0 || gap != 6) begin n_fail++; $display("FAIL default_tick: offset %0d gap %0d expected 0 6", off, gap); end
        n_checks++; if (cur_div !== 8'd6) begin n_fail++; $display("FAIL default_cur_div: got %0d expected 6", cur_div); end
    endtask

    task automatic test_mid_load;
        int l, t0, na, k; longint hi, per, off; int gap;
        k = 0;
        while (clk_out !== 1'b1 && k < 20) begin step(1); k++; end
        na = ack_c.size();
        div_load = 1'b1; div_val = 8'd5; l = cyc + 1; step(1); div_load = 1'b0;
        wait_ack(na, 20);
        t0 = latest_tick(l);
        n_checks++; if (ack_c.size() != na + 1 || ack_c[na] != t0 + 5) begin n_fail++; $display("FAIL mid_load_ack: got %0d expected %0d", ack_c.size() > na ? ack_c[na] : -1, t0 + 5); end
        n_checks++; if (cur_div !== 8'd5) begin n_fail++; $display("FAIL mid_load_cur_div: got %0d expected 5", cur_div); end
        measure(hi, per, off, gap);
        n_checks++; if (per != 100 || hi != 50) begin n_fail++; $display("FAIL n5_timing: period %0d high %0d expected 100 50", per, hi); end
        n_checks++; if (off != 10 || gap != 5 || ack_c.size() != na + 1) begin n_fail++; $display("FAIL n5_tick: offset %0d gap %0d acks %0d expected 10 5 %0d", off, gap, ack_c.size(), na + 1); end
    endtask

    task automatic test_double_load;
        int l, t0, na, nt, k; longint hi, per, off; int gap;
        na = ack_c.size(); nt = tick_c.size(); k = 0;
        while (tick_c.size() == nt && k < 20) begin step(1); k++; end
        div_load = 1'b1; div_val = 8'd3; l = cyc + 1; step(1);
        div_val = 8'd7; step(1); div_load = 1'b0;
        wait_ack(na, 20);
        step(3);
        t0 = latest_tick(l);
        n_checks++; if (ack_c.size() != na + 1 || ack_c[na] != t0 + 4) begin n_fail++; $display("FAIL double_load_ack: count %0d at %0d expected 1 at %0d", ack_c.size() - na, ack_c.size() > na ? ack_c[na] : -1, t0 + 4); end
        n_checks++; if (cur_div !== 8'd7) begin n_fail++; $display("FAIL double_load_cur_div: got %0d expected 7", cur_div); end
        measure(hi, per, off, gap);
        n_checks++; if (per != 140 || hi != 70 || gap != 7) begin n_fail++; $display("FAIL n7_timing: period %0d high %0d gap %0d expected 140 70 7", per, hi, gap); end
    endtask

    task automatic test_reject;
        int l, na, ne; longint hi, per, off; int gap;
        na = ack_c.size(); ne = err_c.size();
        div_load = 1'b1; div_val = 8'd1; l = cyc + 1; step(1);
        div_val = 8'd0; step(1); div_load = 1'b0;
        step(20);
        n_checks++; if (err_c.size() != ne + 2 || err_c[ne] != l || err_c[ne+1] != l + 1) begin n_fail++; $display("FAIL reject_err: count %0d expected 2 starting at %0d", err_c.size() - ne, l); end
        n_checks++; if (ack_c.size() != na || cur_div !== 8'd7) begin n_fail++; $display("FAIL reject_state: acks %0d cur_div %0d expected 0 7", ack_c.size() - na, cur_div); end
        measure(hi, per, off, gap);
        n_checks++; if (per != 140 || hi != 70) begin n_fail++; $display("FAIL reject_timing: period %0d high %0d expected 140 70", per, hi); end
    endtask

    task automatic test_en_drop;
        int d, e, t0, na, nr, nt, k;
        na = ack_c.size();
        div_load = 1'b1; div_val = 8'd6; step(1); div_load = 1'b0;
        wait_ack(na, 20);
        n_checks++; if (cur_div !== 8'd6) begin n_fail++; $display("FAIL en_drop_setup: cur_div %0d expected 6", cur_div); end
        k = 0;
        while (clk_out !== 1'b1 && k < 20) begin step(1); k++; end
        nr = rise_t.size(); d = cyc + 1; en = 1'b0;
        step(40);
        t0 = latest_tick(d);
        n_checks++; if (tick_c[tick_c.size()-1] != t0 || rise_t.size() != nr || clk_out !== 1'b0) begin n_fail++; $display("FAIL en_drop_stop: last tick %0d rises %0d clk_out %b expected %0d %0d 0", tick_c[tick_c.size()-1], rise_t.size(), clk_out, t0, nr); end
        n_checks++; if (fall_t[fall_t.size()-1] - rise_t[nr-1] != 60) begin n_fail++; $display("FAIL en_drop_high: got %0d expected 60", fall_t[fall_t.size()-1] - rise_t[nr-1]); end
        nt = tick_c.size(); en = 1'b1; e = cyc + 1;
        step(3);
        n_checks++; if (tick_c.size() <= nt || tick_c[nt] != e + 1) begin n_fail++; $display("FAIL en_restart_tick: got %0d expected %0d", tick_c.size() > nt ? tick_c[nt] : -1, e + 1); end
        n_checks++; if (rise_t.size() <= nr || tick_t.size() <= nt || rise_t[nr] != tick_t[nt]) begin n_fail++; $display("FAIL en_restart_rise: rise %0t tick %0t expected equal", rise_t.size() > nr ? rise_t[nr] : 0, tick_t.size() > nt ? tick_t[nt] : 0); end
    endtask

    task automatic test_random_loads;
        int n, old, l, t0, na; longint hi, per, off; int gap;
        for (int it = 0; it < 8; it++) begin
            old = int'(cur_div);
            n = $urandom_range(2, 24);
            step($urandom_range(0, old + 2));
            na = ack_c.size();
            div_load = 1'b1; div_val = W'(n); l = cyc + 1; step(1); div_load = 1'b0;
            wait_ack(na, 60);
            t0 = latest_tick(l);
            n_checks++; if (ack_c.size() <= na || ack_c[na] != t0 + old - 1) begin n_fail++; $display("FAIL rand_ack[%0d]: got %0d expected %0d (old %0d new %0d)", it, ack_c.size() > na ? ack_c[na] : -1, t0 + old - 1, old, n); end
            n_checks++; if (cur_div !== W'(n)) begin n_fail++; $display("FAIL rand_cur_div[%0d]: got %0d expected %0d", it, cur_div, n); end
            measure(hi, per, off, gap);
            n_checks++; if (per != n * 20 || hi != n * 10) begin n_fail++; $display("FAIL rand_timing[%0d]: period %0d high %0d expected %0d %0d", it, per, hi, n * 20, n * 10); end
            n_checks++; if (off != ((n % 2) ? 10 : 0) || gap != n) begin n_fail++; $display("FAIL rand_tick[%0d]: offset %0d gap %0d expected %0d %0d", it, off, gap, (n % 2) ? 10 : 0, n); end
        end
    endtask

    task automatic test_reset_pending;
        int na, nt, r; longint hi, per, off; int gap;
        na = ack_c.size();
        div_load = 1'b1; div_val = 8'd12; step(1); div_load = 1'b0;
        wait_ack(na, 40);
        nt = tick_c.size(); r = 0;
        while (tick_c.size() == nt && r < 40) begin step(1); r++; end
        div_load = 1'b1; div_val = 8'd9; step(1); div_load = 1'b0;
        na = ack_c.size();
        #3;
        n_checks++; if (clk_out !== 1'b1) begin n_fail++; $display("FAIL pre_reset_high: got %b expected 1", clk_out); end
        sys_rst = 1'b1;
        #1;
        n_checks++; if (clk_out !== 1'b0 || cur_div !== 8'd6) begin n_fail++; $display("FAIL async_reset: clk_out %b cur_div %0d expected 0 6", clk_out, cur_div); end
        step(2);
        nt = tick_c.size(); sys_rst = 1'b0; r = cyc + 1;
        step(30);
        n_checks++; if (ack_c.size() != na || cur_div !== 8'd6) begin n_fail++; $display("FAIL reset_drops_pending: acks %0d cur_div %0d expected 0 6", ack_c.size() - na, cur_div); end
        n_checks++; if (tick_c.size() <= nt || tick_c[nt] != r + 1) begin n_fail++; $display("FAIL post_reset_tick: got %0d expected %0d", tick_c.size() > nt ? tick_c[nt] : -1, r + 1); end
        measure(hi, per, off, gap);
        n_checks++; if (per != 120 || hi != 60) begin n_fail++; $display("FAIL post_reset_timing: period %0d high %0d expected 120 60", per, hi); end
    endtask

    task automatic test_max_div;
        int na; longint hi, per, off; int gap;
        na = ack_c.size();
        div_load = 1'b1; div_val = 8'd255; step(1); div_load = 1'b0;
        wait_ack(na, 30);
        n_checks++; if (cur_div !== 8'd255) begin n_fail++; $display("FAIL max_cur_div: got %0d expected 255", cur_div); end
        measure(hi, per, off, gap);
        n_checks++; if (per != 5100 || hi != 2550) begin n_fail++; $display("FAIL max_timing: period %0d high %0d expected 5100 2550", per, hi); end
        n_checks++; if (off != 10 || gap != 255) begin n_fail++; $display("FAIL max_tick: offset %0d gap %0d expected 10 255", off, gap); end
    endtask

    initial begin
        test_reset;
        test_default;
        test_mid_load;
        test_double_load;
        test_reject;
        test_en_drop;
        test_random_loads;
        test_reset_pending;
        test_max_div;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
